coin_acceptor: RTL

Front-end stage of the vending-machine design that conditions the two mechanical coin-slot sensors and produces the one-cycle coin code consumed on the `D_in[1:0]` input of the Mealy and Moore vending FSMs. It synchronises each raw sensor, debounces it, converts each validated insertion into a single-cycle code, and serialises simultaneous insertions. It also rejects coins while acceptance is disabled.

---
 rtl/coin_pkg.sv | 25 ++
 rtl/coin_debounce.sv | 76 +++++++
 rtl/coin_acceptor.sv | 94 +++++++++
 3 files changed

// File: rtl/coin_pkg.sv
// Shared coin codes, coin values and debouncer state encoding for the
// coin acceptor front end.
package coin_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_10 = 8'd10;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } deb_state_t;

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  coin_value = VAL_5;
      COIN_10: coin_value = VAL_10;
      default: coin_value = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: 2-flop synchroniser, press/release debounce FSM and a
// registered single-cycle press strobe per validated insertion.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync;
  logic             level;
  deb_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             press_n;

  assign level = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], raw};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      press <= press_n;
    end
  end

  // A full run of N samples validates the level even if the next sample flips.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    press_n = 1'b0;
    case (state)
      IDLE: begin
        if (cnt == CNT_MAX) begin
          state_n = HELD;
          cnt_n   = '0;
          press_n = 1'b1;
        end else if (level) begin
          cnt_n = cnt + 1'b1;
        end else begin
          cnt_n = '0;
        end
      end
      HELD: begin
        if (cnt == CNT_MAX) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!level) begin
          cnt_n = cnt + 1'b1;
        end else begin
          cnt_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor top: two debounced channels, 10c-first arbitration with
// pending flags, accept/reject gating. Optional credit total: COIN_TOTAL_EN.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Coin5_raw,
  input  logic       Coin10_raw,
  input  logic       Accept_en,
`ifdef COIN_TOTAL_EN
  input  logic       Credit_clr,
  output logic [7:0] Credit,
`endif
  output logic [1:0] D_coin,
  output logic       Reject
);

  logic       press5, press10;
  logic       pend5, pend5_n;
  logic       pend10, pend10_n;
  logic [1:0] emit;
  logic [1:0] d_coin_n;
  logic       reject_n;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb5 (
    .clk   (Clk),
    .rst_n (Reset),
    .raw   (Coin5_raw),
    .press (press5)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb10 (
    .clk   (Clk),
    .rst_n (Reset),
    .raw   (Coin10_raw),
    .press (press10)
  );

  // Pending coins drain before new strobes; any strobe not emitted this
  // cycle is parked in its flag (channel spacing keeps flags from overflowing).
  always_comb begin
    emit     = COIN_NONE;
    pend5_n  = pend5;
    pend10_n = pend10;
    if (pend5) begin
      emit     = COIN_5;
      pend5_n  = press5;
      pend10_n = pend10 | press10;
    end else if (pend10) begin
      emit     = COIN_10;
      pend10_n = press10;
      pend5_n  = press5;
    end else if (press10) begin
      emit    = COIN_10;
      pend5_n = press5;
    end else if (press5) begin
      emit = COIN_5;
    end
    d_coin_n = Accept_en ? emit : COIN_NONE;
    reject_n = !Accept_en && (emit != COIN_NONE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pend5  <= 1'b0;
      pend10 <= 1'b0;
      D_coin <= COIN_NONE;
      Reject <= 1'b0;
    end else begin
      pend5  <= pend5_n;
      pend10 <= pend10_n;
      D_coin <= d_coin_n;
      Reject <= reject_n;
    end
  end

`ifdef COIN_TOTAL_EN
  logic [8:0] credit_sum;

  assign credit_sum = {1'b0, Credit} + {1'b0, coin_value(D_coin)};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)               Credit <= 8'd0;
    else if (Credit_clr)      Credit <= 8'd0;
    else if (credit_sum[8])   Credit <= 8'd255;
    else                      Credit <= credit_sum[7:0];
  end
`endif

endmodule
